zorro2_bus_arbiter: RTL and testbench

- Grant-side, three-wire (BR/BG/BGACK) 68000-style bus arbiter for the accelerator board; the responder to the requester logic that drives BR_n and samples BG_n.
- Arbitrates up to NUM_REQ external DMA masters (SDIO card DMA, Zorro II slots) against the local 68SEC000, which owns the bus by default.
- Holds the local CPU off the bus while an external master owns it.
- Runs on C7M, same domain as the bootstrap/bus-arbitration logic.

---
 rtl/zii_bus_pkg.sv | 17 +
 rtl/bus_sync.sv | 27 ++
 rtl/zorro2_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_zorro2_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zii_bus_pkg.sv
// Shared types and constants for the Zorro II bus arbitration logic.
package zii_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    GRANT   = 3'd2,
    OWNED   = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  localparam int DEF_GRANT_TIMEOUT = 16;

  localparam logic ASSERTED_N = 1'b0;
  localparam logic NEGATED_N  = 1'b1;

endpackage

// File: rtl/bus_sync.sv
// Multi-stage synchronizer for asynchronous bus signals; reset loads PRESET
// so that an active-low line reads as idle until real samples arrive.
module bus_sync #(
  parameter int               WIDTH  = 1,
  parameter int               STAGES = 2,
  parameter logic [WIDTH-1:0] PRESET = '1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= PRESET;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zorro2_bus_arbiter.sv
// Grant-side BR/BG/BGACK arbiter: lends the local 68SEC000 bus to one
// external DMA master at a time and holds the CPU off while it is lent.
module zorro2_bus_arbiter
  import zii_bus_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int ROUND_ROBIN   = 0
) (
  input  logic               C7M,
  input  logic               RESET_n,
  input  logic [NUM_REQ-1:0] BR_n_IN,
  input  logic               BGACK_n,
  input  logic               AS_n,
  output logic [NUM_REQ-1:0] BG_n_OUT,
  output logic               CPU_HOLD_n,
  output logic [1:0]         OWNER,
  output logic               OWNER_VALID,
  output logic               TIMEOUT
);

  localparam int             TW       = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMR_LAST = TW'(GRANT_TIMEOUT - 1);
  localparam logic [TW-1:0]  TMR_MAX  = '1;
  localparam logic [1:0]     LAST_IDX = 2'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] br_s;
  logic               bgack_s;
  logic               as_s;

  bus_sync #(.WIDTH(NUM_REQ), .STAGES(SYNC_STAGES), .PRESET({NUM_REQ{NEGATED_N}})) u_sync_br (
    .clk_i   (C7M),
    .rst_n_i (RESET_n),
    .d_i     (BR_n_IN),
    .q_o     (br_s)
  );

  bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .PRESET(NEGATED_N)) u_sync_bgack (
    .clk_i   (C7M),
    .rst_n_i (RESET_n),
    .d_i     (BGACK_n),
    .q_o     (bgack_s)
  );

  bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .PRESET(NEGATED_N)) u_sync_as (
    .clk_i   (C7M),
    .rst_n_i (RESET_n),
    .d_i     (AS_n),
    .q_o     (as_s)
  );

  // Rotating the request vector right by ptr makes the round-robin search a
  // plain lowest-set-bit search; the found offset is then rotated back.
  function automatic logic [1:0] pick_winner(input logic [NUM_REQ-1:0] active,
                                             input logic [1:0]         ptr);
    logic [NUM_REQ-1:0] rot;
    logic [1:0]         off;
    logic [2:0]         sum;
    if (ROUND_ROBIN != 0) rot = NUM_REQ'({active, active} >> ptr);
    else                  rot = active;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if ((rot & (NUM_REQ'(1) << k)) != '0) off = 2'(k);
    end
    sum = {1'b0, off} + ((ROUND_ROBIN != 0) ? {1'b0, ptr} : 3'd0);
    if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
    return sum[1:0];
  endfunction

  arb_state_e         state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               timeout_d;
  logic [NUM_REQ-1:0] bg_n_q, bg_n_d;
  logic               hold_n_q;
  logic               valid_q;
  logic               timeout_q;

  logic [NUM_REQ-1:0] br_active;
  logic               any_req;
  logic               owner_req;

  assign br_active = ~br_s;
  assign any_req   = |br_active;
  assign owner_req = |(br_active & (NUM_REQ'(1) << owner_q));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req && bgack_s == NEGATED_N) state_d = PENDING;
      end
      PENDING: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (as_s == NEGATED_N) begin
          owner_d = pick_winner(br_active, rr_ptr_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Acknowledge wins over withdrawal and timeout in the same cycle.
        if (bgack_s == ASSERTED_N && as_s == NEGATED_N) begin
          state_d = OWNED;
        end else if (bgack_s == NEGATED_N && !owner_req) begin
          state_d = IDLE;
        end else if (bgack_s == NEGATED_N && timer_q == TMR_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      OWNED: begin
        if (bgack_s == NEGATED_N) state_d = RELEASE;
      end
      RELEASE: begin
        rr_ptr_d = (owner_q == LAST_IDX) ? 2'd0 : 2'(owner_q + 2'd1);
        state_d  = any_req ? PENDING : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == GRANT && state_q != GRANT) begin
      timer_d = '0;
    end else if (state_q == GRANT && timer_q != TMR_MAX) begin
      timer_d = timer_q + 1'b1;
    end

    bg_n_d = {NUM_REQ{NEGATED_N}};
    if (state_d == GRANT) bg_n_d = ~(NUM_REQ'(1) << owner_d);
  end

  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      bg_n_q    <= {NUM_REQ{NEGATED_N}};
      hold_n_q  <= NEGATED_N;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      bg_n_q    <= bg_n_d;
      hold_n_q  <= (state_d == IDLE) ? NEGATED_N : ASSERTED_N;
      valid_q   <= (state_d == GRANT) || (state_d == OWNED);
      timeout_q <= timeout_d;
    end
  end

  assign BG_n_OUT    = bg_n_q;
  assign CPU_HOLD_n  = hold_n_q;
  assign OWNER       = owner_q;
  assign OWNER_VALID = valid_q;
  assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_zorro2_bus_arbiter.sv
// Directed bench: fixed-priority and round-robin arbiters share one stimulus.
module tb_zorro2_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] br_n;
  logic       bgack_n;
  logic       as_n;

  logic [1:0] bg0, bg1;
  logic       hold0, hold1;
  logic [1:0] own0, own1;
  logic       ov0, ov1;
  logic       to0, to1;

  int errors = 0;
  int checks = 0;

  zorro2_bus_arbiter #(.NUM_REQ(2), .SYNC_STAGES(2), .GRANT_TIMEOUT(16), .ROUND_ROBIN(0)) dut0 (
    .C7M         (clk),
    .RESET_n     (rst_n),
    .BR_n_IN     (br_n),
    .BGACK_n     (bgack_n),
    .AS_n        (as_n),
    .BG_n_OUT    (bg0),
    .CPU_HOLD_n  (hold0),
    .OWNER       (own0),
    .OWNER_VALID (ov0),
    .TIMEOUT     (to0)
  );

  zorro2_bus_arbiter #(.NUM_REQ(2), .SYNC_STAGES(2), .GRANT_TIMEOUT(16), .ROUND_ROBIN(1)) dut1 (
    .C7M         (clk),
    .RESET_n     (rst_n),
    .BR_n_IN     (br_n),
    .BGACK_n     (bgack_n),
    .AS_n        (as_n),
    .BG_n_OUT    (bg1),
    .CPU_HOLD_n  (hold1),
    .OWNER       (own1),
    .OWNER_VALID (ov1),
    .TIMEOUT     (to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " bg0"}, 32'(bg0), 32'h3);
    check_val({tag, " bg1"}, 32'(bg1), 32'h3);
    check_val({tag, " hold0"}, 32'(hold0), 32'h1);
    check_val({tag, " hold1"}, 32'(hold1), 32'h1);
    check_val({tag, " own0"}, 32'(own0), 32'h0);
    check_val({tag, " own1"}, 32'(own1), 32'h0);
    check_val({tag, " ov0"}, 32'(ov0), 32'h0);
    check_val({tag, " ov1"}, 32'(ov1), 32'h0);
    check_val({tag, " to0"}, 32'(to0), 32'h0);
    check_val({tag, " to1"}, 32'(to1), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    br_n    = 2'b11;
    bgack_n = 1'b1;
    as_n    = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // single request from master 0
    br_n = 2'b10;
    tick(3);
    check_val("single hold_low", 32'(hold0), 32'h0);
    check_val("single bg_edge3", 32'(bg0), 32'h3);
    tick(1);
    check_val("single bg0_edge4", 32'(bg0), 32'h2);
    check_val("single bg1_edge4", 32'(bg1), 32'h2);
    check_val("single owner", 32'(own0), 32'h0);
    check_val("single valid", 32'(ov0), 32'h1);
    bgack_n = 1'b0;
    br_n    = 2'b11;
    tick(2);
    check_val("ack bg_still_low", 32'(bg0), 32'h2);
    tick(1);
    check_val("ack bg_released", 32'(bg0), 32'h3);
    check_val("ack valid", 32'(ov0), 32'h1);
    check_val("ack hold", 32'(hold0), 32'h0);
    tick(3);
    bgack_n = 1'b1;
    tick(3);
    check_val("release hold_turnaround", 32'(hold0), 32'h0);
    tick(1);
    check_val("release hold0_high", 32'(hold0), 32'h1);
    check_val("release hold1_high", 32'(hold1), 32'h1);
    check_val("release valid", 32'(ov0), 32'h0);

    // CPU cycle in progress blocks the grant
    as_n = 1'b0;
    br_n = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_val("as_busy bg", 32'(bg0), 32'h3);
    end
    check_val("as_busy hold", 32'(hold0), 32'h0);
    as_n = 1'b1;
    tick(2);
    check_val("as_free bg_edge2", 32'(bg0), 32'h3);
    tick(1);
    check_val("as_free bg_edge3", 32'(bg0), 32'h2);
    br_n = 2'b11;
    tick(3);
    check_val("as_free withdrawn", 32'(bg0), 32'h3);
    tick(2);

    // withdrawal by master 1 before acknowledge
    br_n = 2'b01;
    tick(4);
    check_val("wd bg0", 32'(bg0), 32'h1);
    check_val("wd bg1", 32'(bg1), 32'h1);
    check_val("wd owner", 32'(own0), 32'h1);
    br_n = 2'b11;
    tick(2);
    check_val("wd bg_still_low", 32'(bg0), 32'h1);
    tick(1);
    check_val("wd bg_off", 32'(bg0), 32'h3);
    check_val("wd hold", 32'(hold0), 32'h1);
    check_val("wd valid", 32'(ov0), 32'h0);
    check_val("wd timeout", 32'(to0), 32'h0);
    tick(2);
    check_val("wd timeout_later", 32'(to0), 32'h0);

    // grant timeout: BGACK never comes
    br_n = 2'b10;
    tick(19);
    check_val("to bg_before", 32'(bg0), 32'h2);
    check_val("to pulse_before", 32'(to0), 32'h0);
    tick(1);
    check_val("to pulse0", 32'(to0), 32'h1);
    check_val("to pulse1", 32'(to1), 32'h1);
    check_val("to bg_off", 32'(bg0), 32'h3);
    check_val("to hold", 32'(hold0), 32'h1);
    br_n = 2'b11;
    tick(1);
    check_val("to pulse_once", 32'(to0), 32'h0);
    tick(6);
    check_val("to settled bg", 32'(bg0), 32'h3);
    check_val("to settled hold", 32'(hold0), 32'h1);

    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // simultaneous requests, both held through the first ownership
    br_n = 2'b00;
    tick(4);
    check_val("sim first bg0", 32'(bg0), 32'h2);
    check_val("sim first bg1", 32'(bg1), 32'h2);
    bgack_n = 1'b0;
    tick(3);
    check_val("sim owned bg0", 32'(bg0), 32'h3);
    check_val("sim owned bg1", 32'(bg1), 32'h3);
    tick(2);
    bgack_n = 1'b1;
    tick(3);
    check_val("sim release hold0", 32'(hold0), 32'h0);
    check_val("sim release hold1", 32'(hold1), 32'h0);
    tick(1);
    check_val("sim pending hold0", 32'(hold0), 32'h0);
    tick(1);
    check_val("sim fixed bg", 32'(bg0), 32'h2);
    check_val("sim fixed owner", 32'(own0), 32'h0);
    check_val("sim rr bg", 32'(bg1), 32'h1);
    check_val("sim rr owner", 32'(own1), 32'h1);

    // reset while owned
    bgack_n = 1'b0;
    tick(3);
    check_val("rst owned ov0", 32'(ov0), 32'h1);
    check_val("rst owned ov1", 32'(ov1), 32'h1);
    check_val("rst owned bg0", 32'(bg0), 32'h3);
    rst_n   = 1'b0;
    bgack_n = 1'b1;
    br_n    = 2'b11;
    tick(1);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    tick(3);
    br_n = 2'b01;
    tick(4);
    check_val("rearb bg0", 32'(bg0), 32'h1);
    check_val("rearb bg1", 32'(bg1), 32'h1);
    check_val("rearb owner1", 32'(own1), 32'h1);
    br_n = 2'b11;
    tick(4);

    // held request 1 follows master 0 without releasing the CPU
    br_n = 2'b00;
    tick(4);
    check_val("held first bg0", 32'(bg0), 32'h2);
    check_val("held first bg1", 32'(bg1), 32'h2);
    bgack_n = 1'b0;
    br_n    = 2'b01;
    tick(3);
    check_val("held owned bg0", 32'(bg0), 32'h3);
    check_val("held owned hold", 32'(hold0), 32'h0);
    tick(1);
    bgack_n = 1'b1;
    tick(3);
    check_val("held release hold", 32'(hold0), 32'h0);
    tick(1);
    check_val("held pending hold", 32'(hold0), 32'h0);
    tick(1);
    check_val("held second bg0", 32'(bg0), 32'h1);
    check_val("held second bg1", 32'(bg1), 32'h1);
    check_val("held second owner", 32'(own0), 32'h1);
    check_val("held second hold", 32'(hold0), 32'h0);
    bgack_n = 1'b0;
    br_n    = 2'b11;
    tick(3);
    bgack_n = 1'b1;
    tick(4);
    check_val("held done hold0", 32'(hold0), 32'h1);
    check_val("held done hold1", 32'(hold1), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
